osd_dem_uart_bus_arb: RTL
=========================

OSD_DEM_UART_BUS_ARB -- requirements
Module: osd_dem_uart_bus_arb

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters sharing one UART register bus (range 2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles in GRANT without bus_ack; 0 disables timeout.
REQ-003 SHALL have one clock and asynchronous active-high reset; ports: clk input 1, rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req_valid  input  NREQ  per-requester access request, held until its req_ack.
REQ-006 req_addr  input  NREQ x 3  per-requester 16550 register address.
REQ-007 req_write  input  NREQ  per-requester 1 = write, 0 = read.
REQ-008 req_wdata  input  NREQ x 8  per-requester write data.
REQ-009 req_ack  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-010 req_err  output  1  qualifies req_ack: 1 = timed out.
REQ-011 req_rdata  output  8  read data, valid while req_ack is high.
REQ-012 bus_req, bus_addr[2:0], bus_write, bus_wdata[7:0]  outputs  register-bus request to the 16550 emulation.
REQ-013 bus_ack  input  1  and bus_rdata  input  8  register-bus completion and read data.

Function
REQ-014 SHALL implement states IDLE, GRANT, DONE.
- IDLE: if any req_valid, pick winner round-robin starting at pointer ptr; latch addr/write/wdata/index; -> GRANT.
- GRANT: bus_req=1 with latched fields, stable throughout; on bus_ack latch bus_rdata, err=0 -> DONE; on timeout -> DONE with err=1.
- DONE: req_ack[idx]=1 for exactly one cycle, req_rdata/req_err valid; -> IDLE.
REQ-015 All outputs SHALL be registered; bus_req rises one cycle after req_valid seen in IDLE.
REQ-016 Latency: req_ack SHALL pulse exactly one cycle after the bus_ack cycle; minimum request-to-ack latency 3 cycles (bus_ack same cycle bus_req first high).
REQ-017 On grant, ptr SHALL become (idx+1) mod NREQ; a requester just served is lowest priority next arbitration.
REQ-018 Requester dropping req_valid while in GRANT SHALL NOT abort the bus access; ack pulse still issued.
REQ-019 Requester SHALL drop req_valid in the cycle req_ack is high; arbiter re-samples req_valid only in IDLE (DONE->IDLE inserts one idle cycle, no back-to-back grant).
REQ-020 Timeout counter (8..16 bit, width from TIMEOUT) SHALL clear on entering GRANT, increment each GRANT cycle, expire when count == TIMEOUT-1 without bus_ack.
REQ-021 Timeout: bus_req SHALL drop, req_rdata SHALL be 8'hFF, req_err=1.
REQ-022 bus_ack and timeout expiry in the same cycle: bus_ack wins, err=0.
REQ-023 bus_ack outside GRANT SHALL be ignored.
REQ-024 req_rdata on write completion SHALL be 8'h00; req_err low except with req_ack.

Reset
REQ-025 rst SHALL asynchronously force state IDLE, ptr 0, counter 0, bus_req 0, req_ack 0, req_err 0, req_rdata 0, bus_addr/bus_write/bus_wdata 0.
REQ-026 Reset mid-GRANT SHALL drop bus_req immediately without issuing req_ack; interrupted transaction is lost.

Structure
REQ-027 Shared package SHALL hold the 16550 bus address width (3), data width (8) and the arbiter state enum.
REQ-028 Round-robin winner selection SHALL be one sub-module, osd_dem_uart_rr_pick (inputs valid vector, ptr; outputs index, any).

Verification
REQ-029 Single read: req_valid[0], addr 5, bus_ack after 2 cycles with rdata 8'h60 -> req_ack[0] pulse, req_rdata 8'h60, err 0.
REQ-030 Contention: req_valid 2'b11 held continuously from reset -> grants alternate 0,1,0,1; each ack one cycle.
REQ-031 Timeout: TIMEOUT=4, bus_ack never -> bus_req high 4 cycles, req_ack with err 1, rdata 8'hFF.
REQ-032 Boundary: bus_ack on the expiry cycle -> err 0, rdata = bus_rdata.
REQ-033 Write: req1 write addr 0 data 8'h41 -> bus_addr 0, bus_wdata 8'h41, bus_write 1 stable until bus_ack; req_ack[1], rdata 8'h00.
REQ-034 Reset mid-GRANT: assert rst asynchronously -> bus_req 0 same cycle, no req_ack; next request granted normally with ptr 0.

Source files
------------

// File: rtl/osd_dem_uart_bus_arb_pkg.sv
// Shared definitions for the UART register-bus arbiter: 16550 bus widths,
// arbiter state encoding and small elaboration-time helpers.
package osd_dem_uart_bus_arb_pkg;

  // 16550 register bus geometry
  localparam int BUS_AW = 3;
  localparam int BUS_DW = 8;

  // Read data returned on a timed-out access and on any write completion
  localparam logic [BUS_DW-1:0] RDATA_TIMEOUT = 8'hFF;
  localparam logic [BUS_DW-1:0] RDATA_WRITE   = 8'h00;

  // Arbiter state
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_e;

  // Timeout counter width: enough bits for TIMEOUT, clamped to 8..16
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    if (w < 8)  w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

  // Requester index width (at least one bit)
  function automatic int idx_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/osd_dem_uart_rr_pick.sv
// Round-robin winner selection: the first valid requester at or above the
// pointer wins, otherwise the first valid requester below the pointer.
module osd_dem_uart_rr_pick
  import osd_dem_uart_bus_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  i_valid,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Two-pass priority scan without a rotated (dynamically indexed) vector
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_idx = '0;
    o_any = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!o_any && i_valid[j] && (j >= int'(i_ptr))) begin
        o_any = 1'b1;
        o_idx = IDX_W'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!o_any && i_valid[j] && (j < int'(i_ptr))) begin
        o_any = 1'b1;
        o_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/osd_dem_uart_bus_arb.sv
// Arbiter giving NREQ requesters round-robin access to one 16550 register
// bus. One access at a time: IDLE picks a winner, GRANT drives the bus until
// bus_ack or timeout, DONE pulses the winner's req_ack for one cycle.
module osd_dem_uart_bus_arb
  import osd_dem_uart_bus_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ-1:0][BUS_AW-1:0]   req_addr,
  input  logic [NREQ-1:0]               req_write,
  input  logic [NREQ-1:0][BUS_DW-1:0]   req_wdata,
  output logic [NREQ-1:0]               req_ack,
  output logic                          req_err,
  output logic [BUS_DW-1:0]             req_rdata,
  output logic                          bus_req,
  output logic [BUS_AW-1:0]             bus_addr,
  output logic                          bus_write,
  output logic [BUS_DW-1:0]             bus_wdata,
  input  logic                          bus_ack,
  input  logic [BUS_DW-1:0]             bus_rdata
);

  localparam int IDX_W = idx_width(NREQ);
  localparam int CW    = cnt_width(TIMEOUT);
  // Last counter value before expiry; unused when TIMEOUT is 0
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  arb_state_e         r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_idx;
  logic [CW-1:0]      r_cnt;
  logic               r_bus_req;
  logic [BUS_AW-1:0]  r_bus_addr;
  logic               r_bus_write;
  logic [BUS_DW-1:0]  r_bus_wdata;
  logic [NREQ-1:0]    r_req_ack;
  logic               r_req_err;
  logic [BUS_DW-1:0]  r_req_rdata;

  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic [IDX_W-1:0]   w_ptr_next;
  logic               w_expire;

  osd_dem_uart_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // The requester just granted becomes lowest priority next time
  assign w_ptr_next = (w_idx == IDX_W'(NREQ - 1)) ? '0 : w_idx + IDX_W'(1);

  // Timeout fires on the GRANT cycle whose count reaches TIMEOUT-1
  assign w_expire = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  // Arbiter FSM and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_write <= 1'b0;
      r_bus_wdata <= '0;
      r_req_ack   <= '0;
      r_req_err   <= 1'b0;
      r_req_rdata <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
      // Completion strobes default low; they are set only on the edge entering DONE
      r_req_ack <= '0;
      r_req_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state     <= ST_GRANT;
            r_idx       <= w_idx;
            r_ptr       <= w_ptr_next;
            r_cnt       <= '0;
            r_bus_req   <= 1'b1;
            r_bus_addr  <= req_addr[w_idx];
            r_bus_write <= req_write[w_idx];
            r_bus_wdata <= req_wdata[w_idx];
          end
        end
        ST_GRANT: begin
          if (bus_ack) begin
            // bus_ack wins over a simultaneous timeout
            r_state     <= ST_DONE;
            r_bus_req   <= 1'b0;
            r_req_ack   <= ONE_HOT0 << r_idx;
            r_req_rdata <= r_bus_write ? RDATA_WRITE : bus_rdata;
          end else if (w_expire) begin
            r_state     <= ST_DONE;
            r_bus_req   <= 1'b0;
            r_req_ack   <= ONE_HOT0 << r_idx;
            r_req_err   <= 1'b1;
            r_req_rdata <= RDATA_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          // One idle cycle before the next arbitration
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ack   = r_req_ack;
  assign req_err   = r_req_err;
  assign req_rdata = r_req_rdata;
  assign bus_req   = r_bus_req;
  assign bus_addr  = r_bus_addr;
  assign bus_write = r_bus_write;
  assign bus_wdata = r_bus_wdata;

endmodule
